// File: rtl/mux_sequencer.sv
// Steps the front-end bank/channel multiplexers one acquisition slot per SPI word strobe.
// Slot 0 is calibration (programmable reference table); slots 1..N are masked signal channels.
module mux_sequencer #(
  parameter int CH_PER_BANK = 8,
  parameter int NUM_BANKS   = 2,
  parameter int SEL_W       = 3,
  parameter int ADDR_W      = 5,
  parameter int CAL_LEN     = 4,
  parameter int SETTLE      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           spiReceived,
  input  logic [NUM_BANKS*CH_PER_BANK-1:0] chanMask,
  input  logic [CAL_LEN*SEL_W-1:0]       calPattern,
  input  logic                           calEnable,
  input  logic [SEL_W-1:0]               idleCode,
  output logic [SEL_W-1:0]               bankSel,
  output logic [SEL_W-1:0]               chanSel,
  output logic [ADDR_W-1:0]              rxAddress,
  output logic                           selValid,
  output logic                           frameStart,
  output logic                           overrun
);

  // state    | meaning
  // WAIT     | idle, waiting for a strobe edge
  // PREPARE  | scan slots, skipping masked channels, until one is taken
  // SETUP    | apply the taken slot to the mux selects
  // SETTLE   | count down the settle delay, then pulse selValid
  typedef enum logic [1:0] {ST_WAIT, ST_PREPARE, ST_SETUP, ST_SETTLE} state_t;

  localparam int N = NUM_BANKS * CH_PER_BANK;
  localparam int CAL_W = (CAL_LEN > 1) ? $clog2(CAL_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] CH_DIV = ADDR_W'(CH_PER_BANK);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_LEN - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t state, state_nxt;
  logic [2:0]        sync;
  logic              rx_front;
  logic [ADDR_W-1:0] slot, slot_next, idx;
  logic [CAL_W-1:0]  cal;
  logic [SEL_W-1:0]  pend_bank, pend_chan, cal_code, bank_calc, chan_calc;
  logic [ADDR_W-1:0] pend_addr;
  logic [3:0]        cnt;
  logic              take;

  assign rx_front  = !sync[2] && sync[1];
  assign idx       = slot - ADDR_W'(1);
  assign slot_next = (slot == LAST_SLOT) ? '0 : slot + ADDR_W'(1);
  assign bank_calc = SEL_W'(idx / CH_DIV);
  assign chan_calc = SEL_W'(idx % CH_DIV);
  assign cal_code  = calPattern[cal*SEL_W +: SEL_W];
  assign frameStart = selValid && (rxAddress == '0);

  // Slot 0 is always taken, which bounds the skip scan to N clocks.
  always_comb begin
    take = (slot == '0);
    for (int k = 0; k < N; k++) begin
      if (idx == ADDR_W'(k) && slot != '0) take = chanMask[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    selValid  = 1'b0;
    case (state)
      ST_WAIT:    if (rx_front) state_nxt = ST_PREPARE;
      ST_PREPARE: if (take) state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt == '0) begin
          selValid  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      default:    state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync      <= '0;
      slot      <= ADDR_W'(1);
      cal       <= '0;
      pend_bank <= '0;
      pend_chan <= '0;
      pend_addr <= '0;
      bankSel   <= '0;
      chanSel   <= '0;
      rxAddress <= '0;
      cnt       <= '0;
      overrun   <= 1'b0;
    end else begin
      sync <= {sync[1:0], spiReceived};
      if (rx_front && state != ST_WAIT) overrun <= 1'b1;
      case (state)
        ST_PREPARE: begin
          slot <= slot_next;
          if (take) begin
            pend_addr <= slot;
            if (slot == '0) begin
              pend_bank <= calEnable ? cal_code : idleCode;
              pend_chan <= '0;
              if (calEnable) cal <= (cal == CAL_LAST) ? '0 : cal + CAL_W'(1);
            end else begin
              pend_bank <= bank_calc;
              pend_chan <= chan_calc;
            end
          end
        end
        ST_SETUP: begin
          bankSel   <= pend_bank;
          chanSel   <= pend_chan;
          rxAddress <= pend_addr;
          cnt       <= SETTLE_LD;
        end
        ST_SETTLE: if (cnt != '0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sequencer.sv
// Scoreboard bench for mux_sequencer: three instances (SETTLE 2, 0, 3) share stimulus;
// expected slots are queued at strobe time and popped by per-instance monitors on selValid.
module tb_mux_sequencer;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset, spi, cal_en;
  logic [15:0] mask;
  logic [11:0] calp;
  logic [2:0]  idle;

  logic [2:0] bank_m, chan_m, bank_0, chan_0, bank_3, chan_3;
  logic [4:0] addr_m, addr_0, addr_3;
  logic       sv_m, fs_m, ov_m, sv_0, fs_0, ov_0, sv_3, fs_3, ov_3;

  typedef struct {
    int addr;
    int bank;
    int chan;
    int frame;
    int base;
  } entry_t;

  entry_t q_main[$], q_s0[$], q_s3[$];
  entry_t em, e0, e3;
  int checks = 0, failures = 0, cyc = 0, tb_slot = 1, tb_cal = 0;
  int cal_tab[4] = '{5, 2, 5, 3};

  mux_sequencer #(.SETTLE(2)) u_main (
    .clk(clk), .reset(reset), .spiReceived(spi), .chanMask(mask), .calPattern(calp),
    .calEnable(cal_en), .idleCode(idle), .bankSel(bank_m), .chanSel(chan_m),
    .rxAddress(addr_m), .selValid(sv_m), .frameStart(fs_m), .overrun(ov_m));

  mux_sequencer #(.SETTLE(0)) u_s0 (
    .clk(clk), .reset(reset), .spiReceived(spi), .chanMask(mask), .calPattern(calp),
    .calEnable(cal_en), .idleCode(idle), .bankSel(bank_0), .chanSel(chan_0),
    .rxAddress(addr_0), .selValid(sv_0), .frameStart(fs_0), .overrun(ov_0));

  mux_sequencer #(.SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .spiReceived(spi), .chanMask(mask), .calPattern(calp),
    .calEnable(cal_en), .idleCode(idle), .bankSel(bank_3), .chanSel(chan_3),
    .rxAddress(addr_3), .selValid(sv_3), .frameStart(fs_3), .overrun(ov_3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model of the slot walk; base = strobe cycle + 5 + skipped slots.
  task automatic model_take(output entry_t e, input int c0);
    int skips = 0;
    while (tb_slot != 0 && !mask[tb_slot-1]) begin
      skips++;
      tb_slot = (tb_slot == N) ? 0 : tb_slot + 1;
    end
    e.addr = tb_slot;
    e.base = c0 + 5 + skips;
    if (tb_slot == 0) begin
      e.frame = 1;
      e.chan  = 0;
      if (cal_en) begin
        e.bank = cal_tab[tb_cal];
        tb_cal = (tb_cal + 1) % 4;
      end else begin
        e.bank = int'(idle);
      end
    end else begin
      e.frame = 0;
      e.bank  = (tb_slot - 1) / 8;
      e.chan  = (tb_slot - 1) % 8;
    end
    tb_slot = (tb_slot == N) ? 0 : tb_slot + 1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_main.size() + q_s0.size() + q_s3.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if ((q_main.size() + q_s0.size() + q_s3.size()) != 0) begin
      chk("drain_timeout", q_main.size() + q_s0.size() + q_s3.size(), 0);
      q_main.delete(); q_s0.delete(); q_s3.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic issue();
    entry_t e;
    @(posedge clk); #1;
    model_take(e, cyc);
    q_main.push_back(e); q_s0.push_back(e); q_s3.push_back(e);
    spi = 1'b1;
    repeat (3) @(posedge clk);
    #1 spi = 1'b0;
    drain();
  endtask

  always @(negedge clk) if (reset) begin
    if (fs_m && !sv_m) chk("main_frame_no_valid", int'(fs_m), 0);
    if (sv_m) begin
      if (q_main.size() == 0) chk("main_unexpected_valid_addr", int'(addr_m), -1);
      else begin
        em = q_main.pop_front();
        chk("main_addr", int'(addr_m), em.addr);
        chk("main_bank", int'(bank_m), em.bank);
        chk("main_chan", int'(chan_m), em.chan);
        chk("main_frame", int'(fs_m), em.frame);
        chk("main_cycle", cyc, em.base + 2);
      end
    end
  end

  always @(negedge clk) if (reset && sv_0) begin
    if (q_s0.size() == 0) chk("s0_unexpected_valid_addr", int'(addr_0), -1);
    else begin
      e0 = q_s0.pop_front();
      chk("s0_addr", int'(addr_0), e0.addr);
      chk("s0_cycle", cyc, e0.base);
    end
  end

  always @(negedge clk) if (reset && sv_3) begin
    if (q_s3.size() == 0) chk("s3_unexpected_valid_addr", int'(addr_3), -1);
    else begin
      e3 = q_s3.pop_front();
      chk("s3_addr", int'(addr_3), e3.addr);
      chk("s3_bank", int'(bank_3), e3.bank);
      chk("s3_cycle", cyc, e3.base + 3);
    end
  end

  initial begin
    entry_t e;
    reset  = 1'b0;
    spi    = 1'b0;
    mask   = 16'hFFFF;
    calp   = {3'd3, 3'd5, 3'd2, 3'd5};
    cal_en = 1'b1;
    idle   = 3'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bank", int'(bank_m), 0);
    chk("rst_chan", int'(chan_m), 0);
    chk("rst_addr", int'(addr_m), 0);
    chk("rst_valid", int'(sv_m), 0);
    chk("rst_frame", int'(fs_m), 0);
    chk("rst_overrun", int'(ov_m), 0);
    reset = 1'b1;

    // First frame, then four more to walk the cal table through its wrap.
    repeat (17) issue();
    chk("overrun_clean", int'(ov_m), 0);
    repeat (68) issue();

    // Sparse mask: slots 1, 9, 0, 1 with seven skipped slots before 9 and before 0.
    mask = 16'h0101;
    repeat (4) issue();

    // Empty mask: slot 0 every edge; idle code with cal disabled, pattern resumes after.
    mask   = 16'h0000;
    cal_en = 1'b0;
    issue();
    cal_en = 1'b1;
    issue();
    mask = 16'hFFFF;

    // Second rising edge two clocks after the first: dropped, overrun set.
    @(posedge clk); #1;
    model_take(e, cyc);
    q_main.push_back(e); q_s0.push_back(e); q_s3.push_back(e);
    spi = 1'b1;
    @(posedge clk); #1 spi = 1'b0;
    @(posedge clk); #1 spi = 1'b1;
    repeat (2) @(posedge clk);
    #1 spi = 1'b0;
    drain();
    chk("overrun_set", int'(ov_m), 1);
    issue();
    chk("overrun_sticky", int'(ov_m), 1);

    // Reset during SETTLE of the SETTLE=2 and SETTLE=3 instances; SETTLE=0 has already fired.
    @(posedge clk); #1;
    model_take(e, cyc);
    q_s0.push_back(e);
    spi = 1'b1;
    repeat (3) @(posedge clk);
    #1 spi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_chan", int'(chan_m), 0);
    chk("midrst_addr", int'(addr_m), 0);
    chk("midrst_valid", int'(sv_m), 0);
    chk("midrst_overrun", int'(ov_m), 0);
    chk("midrst_s3_addr", int'(addr_3), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tb_slot = 1;
    tb_cal  = 0;
    drain();
    issue();
    chk("post_rst_addr", int'(addr_m), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
